mac_cfg_loader: RTL and testbench

- Upstream feeder for the MAC quad-cluster configuration bus.
- Accepts configuration words from the system side over a valid/ready handshake and assembles the full cluster cfg vector: 4 initial accumulator values plus the mode bits.
- Issues a single-cycle cset strobe with cfg held stable, then gates the cluster enable low while the cluster pipeline flushes.

---
 rtl/mac_cfg_pkg.sv | 43 ++++
 rtl/mac_cfg_loader_if.sv | 41 ++++
 rtl/mac_cfg_shifter.sv | 59 +++++
 rtl/mac_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_mac_cfg_loader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_cfg_pkg.sv
// -----------------------------------------------------------------------------
// mac_cfg_pkg
// Shared definitions for the MAC quad-cluster configuration loader:
//   - default parameter values,
//   - CFG_W / NWORDS computations,
//   - loader state encoding,
//   - cfg field offsets (mode bits at the bottom, initial values above).
// -----------------------------------------------------------------------------
package mac_cfg_pkg;

   localparam int MAC_CONF_WIDTH_DEF = 4;
   localparam int MAC_ACC_WIDTH_DEF  = 32;
   localparam int WORD_WIDTH_DEF     = 32;
   localparam int FLUSH_CYCLES_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   function automatic int calc_cfg_w(input int acc_w, input int conf_w);
      return 4 * acc_w + conf_w;
   endfunction

   function automatic int calc_nwords(input int cfg_w, input int word_w);
      return (cfg_w + word_w - 1) / word_w;
   endfunction

   // LSB position of the mode field and of initial accumulator value i
   function automatic int mode_lsb();
      return 0;
   endfunction

   function automatic int init_lsb(input int i, input int acc_w, input int conf_w);
      return conf_w + i * acc_w;
   endfunction

   localparam int CFG_W_DEF  = calc_cfg_w(MAC_ACC_WIDTH_DEF, MAC_CONF_WIDTH_DEF);
   localparam int NWORDS_DEF = calc_nwords(CFG_W_DEF, WORD_WIDTH_DEF);

endpackage

// File: rtl/mac_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// mac_cfg_loader_if
// System-side configuration word handshake.
//   cfg_word   : config word, LSB-first word order
//   cfg_valid  : cfg_word valid
//   cfg_ready  : loader accepts a word this cycle
//   cfg_abort  : discard a partial load
//   cfg_parity : even parity over cfg_word      (MAC_CFG_PARITY_EN only)
//   cfg_err    : sticky parity error flag       (MAC_CFG_PARITY_EN only)
// master = system side, slave = loader.
// -----------------------------------------------------------------------------
interface mac_cfg_loader_if #(
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] cfg_word;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic                  cfg_abort;
`ifdef MAC_CFG_PARITY_EN
   logic                  cfg_parity;
   logic                  cfg_err;

   modport master (
      output cfg_word, cfg_valid, cfg_abort, cfg_parity,
      input  cfg_ready, cfg_err
   );
   modport slave (
      input  cfg_word, cfg_valid, cfg_abort, cfg_parity,
      output cfg_ready, cfg_err
   );
`else
   modport master (
      output cfg_word, cfg_valid, cfg_abort,
      input  cfg_ready
   );
   modport slave (
      input  cfg_word, cfg_valid, cfg_abort,
      output cfg_ready
   );
`endif
endinterface

// File: rtl/mac_cfg_shifter.sv
// -----------------------------------------------------------------------------
// mac_cfg_shifter
// Shadow register plus word counter for the config loader.
//   clk, rst   : clock, async active-low reset
//   shift_en   : accepted word, shift it in at the top
//   cnt_clr    : restart word counting (abort / rejected word)
//   word       : incoming config word
//   shadow     : NWORDS*WORD_WIDTH assembled shadow register
//   last_word  : the next accepted word completes the load
// -----------------------------------------------------------------------------
module mac_cfg_shifter
   import mac_cfg_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int NWORDS     = NWORDS_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         shift_en,
   input  logic                         cnt_clr,
   input  logic [WORD_WIDTH-1:0]        word,
   output logic [NWORDS*WORD_WIDTH-1:0] shadow,
   output logic                         last_word
);

   localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

   logic [CNT_W-1:0] word_cnt;

   assign last_word = (word_cnt == LAST_CNT);

   // Words arrive LSB-first: each new word enters at the top and everything
   // moves down, so after NWORDS words word 0 sits at the bottom.
   generate
      if (NWORDS == 1) begin : g_single
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)          shadow <= '0;
            else if (shift_en) shadow <= word;
         end
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)          shadow <= '0;
            else if (shift_en) shadow <= {word, shadow[NWORDS*WORD_WIDTH-1:WORD_WIDTH]};
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
      end else if (cnt_clr) begin
         word_cnt <= '0;
      end else if (shift_en) begin
         word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mac_cfg_loader.sv
// -----------------------------------------------------------------------------
// mac_cfg_loader
// Upstream feeder for the MAC quad-cluster configuration bus. Collects NWORDS
// config words, presents the assembled cfg with a one-cycle cset strobe, then
// holds the cluster enable low for FLUSH_CYCLES while its pipeline drains.
//
// Ports:
//   clk, rst : clock, async active-low reset
//   bus      : config word handshake (mac_cfg_loader_if.slave)
//   en_in    : system enable for the cluster
//   en_out   : gated enable to the cluster
//   cset     : one-cycle config strobe
//   cfg      : assembled config bus {init3, init2, init1, init0, mode}
//   busy     : loader not in IDLE
//   done     : one-cycle pulse on the last FLUSH cycle
//
// Optional: define MAC_CFG_PARITY_EN to add even-parity checking on each
// accepted word (bus.cfg_parity in, sticky bus.cfg_err out).
//
// state  | meaning
// IDLE   | waiting for the first word of a load
// LOAD   | partial load in the shadow register
// COMMIT | cset strobe, cfg holds the final value
// FLUSH  | en_out held low while the cluster pipeline drains
// -----------------------------------------------------------------------------
module mac_cfg_loader
   import mac_cfg_pkg::*;
#(
   parameter int MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
   parameter int MAC_ACC_WIDTH  = MAC_ACC_WIDTH_DEF,
   parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
   parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF
) (
   input  logic                                    clk,
   input  logic                                    rst,
   mac_cfg_loader_if.slave                         bus,
   input  logic                                    en_in,
   output logic                                    en_out,
   output logic                                    cset,
   output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] cfg,
   output logic                                    busy,
   output logic                                    done
);

   localparam int CFG_W  = calc_cfg_w(MAC_ACC_WIDTH, MAC_CONF_WIDTH);
   localparam int NWORDS = calc_nwords(CFG_W, WORD_WIDTH);
   localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   state_t                       state;
   logic [FC_W-1:0]              flush_cnt;
   logic [NWORDS*WORD_WIDTH-1:0] shadow;
   logic                         last_word;
   logic                         ready_st;
   logic                         accept;
   logic                         abort_now;
   logic                         par_bad;

   assign ready_st = (state == IDLE) || (state == LOAD);

   // Qualified with rst so the system sees no ready and the cluster no enable
   // for as long as reset is held, not just after the first clock.
   assign bus.cfg_ready = rst & ready_st;
   assign en_out        = rst & ready_st & en_in;

   // Abort wins over a simultaneous valid word.
   assign abort_now = bus.cfg_abort & ready_st;
   assign accept    = bus.cfg_valid & ready_st & ~bus.cfg_abort;

`ifdef MAC_CFG_PARITY_EN
   assign par_bad = accept & (bus.cfg_parity != ^bus.cfg_word);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          bus.cfg_err <= 1'b0;
      else if (par_bad)                  bus.cfg_err <= 1'b1;
      else if (accept && state == IDLE)  bus.cfg_err <= 1'b0;
   end
`else
   assign par_bad = 1'b0;
`endif

   mac_cfg_shifter #(
      .WORD_WIDTH (WORD_WIDTH),
      .NWORDS     (NWORDS)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (accept),
      .cnt_clr   (abort_now | par_bad),
      .word      (bus.cfg_word),
      .shadow    (shadow),
      .last_word (last_word)
   );

   // The shadow only moves on an accepted word, so cfg stays put from COMMIT
   // until the next load starts.
   assign cfg = shadow[CFG_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         flush_cnt <= '0;
         cset      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cset <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (abort_now || par_bad) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (accept) begin
                  busy <= 1'b1;
                  if (last_word) begin
                     state <= COMMIT;
                     cset  <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            COMMIT: begin
               state     <= FLUSH;
               flush_cnt <= FC_LOAD;
               done      <= (FLUSH_CYCLES == 1);
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
                  done      <= (flush_cnt == FC_W'(1));
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_mac_cfg_loader
// Scoreboard bench: the stimulus side pushes the expected cfg of every
// completed load; a monitor pops and compares on each cset and tracks the
// commit/flush window to check en_out, cfg_ready and done every cycle.
// -----------------------------------------------------------------------------
module tb_mac_cfg_loader;
   import mac_cfg_pkg::*;

   localparam int AW   = MAC_ACC_WIDTH_DEF;
   localparam int CW   = MAC_CONF_WIDTH_DEF;
   localparam int WW   = WORD_WIDTH_DEF;
   localparam int FC   = FLUSH_CYCLES_DEF;
   localparam int CFGW = 4 * AW + CW;
   localparam int NW   = (CFGW + WW - 1) / WW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en_in = 1'b1;
   logic            en_out;
   logic            cset;
   logic [CFGW-1:0] cfg;
   logic            busy;
   logic            done;

   int checks = 0;
   int errors = 0;

   logic [CFGW-1:0] exp_q[$];
   logic [WW-1:0]   cur[$];
   bit              use_literal = 1'b0;
   logic [CFGW-1:0] literal_cfg;
   int              mon_since = -1;
   bit              en_rand = 1'b0;

   always #5 clk = ~clk;

   mac_cfg_loader_if #(.WORD_WIDTH(WW)) bus ();

   mac_cfg_loader #(
      .MAC_CONF_WIDTH (CW),
      .MAC_ACC_WIDTH  (AW),
      .WORD_WIDTH     (WW),
      .FLUSH_CYCLES   (FC)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .en_in  (en_in),
      .en_out (en_out),
      .cset   (cset),
      .cfg    (cfg),
      .busy   (busy),
      .done   (done)
   );

   task automatic check(input string name, input logic [CFGW-1:0] act, input logic [CFGW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: concatenate the words of a load, first word lowest, keep CFGW bits.
   function automatic logic [CFGW-1:0] model_cfg(input logic [WW-1:0] w[$]);
      logic [NW*WW-1:0] full;
      full = '0;
      for (int i = 0; i < NW; i++) full[i*WW +: WW] = w[i];
      return full[CFGW-1:0];
   endfunction

   function automatic void accepted(input logic [WW-1:0] w, input bit bad);
      if (bad) begin
         cur.delete();
      end else begin
         cur.push_back(w);
         if (cur.size() == NW) begin
            exp_q.push_back(use_literal ? literal_cfg : model_cfg(cur));
            cur.delete();
         end
      end
   endfunction

   task automatic send_word(input logic [WW-1:0] w, input bit bad);
      int   n;
      logic rdy;
      n = 0;
      bus.cfg_word  = w;
      bus.cfg_valid = 1'b1;
`ifdef MAC_CFG_PARITY_EN
      bus.cfg_parity = bad ? ~(^w) : ^w;
`endif
      do begin
         @(negedge clk);
         rdy = bus.cfg_ready;
         @(posedge clk);
         n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout word %0h never accepted", w);
      end else begin
         accepted(w, bad);
      end
      #1;
   endtask

   task automatic idle(input int n);
      bus.cfg_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_load();
      for (int i = 0; i < NW; i++) begin
         send_word($urandom, 1'b0);
         if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      end
   endtask

   // Monitor / scoreboard
   initial begin
      logic [CFGW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mon_since = -1;
         end else begin
            if (cset) begin
               check("cset_single", (mon_since >= 0) ? 1'b1 : 1'b0, '0);
               if (exp_q.size() == 0) begin
                  check("cset_unexpected", 1'b1, '0);
               end else begin
                  exp = exp_q.pop_front();
                  check("cfg_at_cset", cfg, exp);
               end
               mon_since = 0;
            end else if (mon_since >= 0) begin
               mon_since++;
               if (mon_since > FC) mon_since = -1;
            end
            check("done", done, (mon_since == FC) ? 1'b1 : 1'b0);
            check("cfg_ready", bus.cfg_ready, (mon_since < 0) ? 1'b1 : 1'b0);
            check("en_out", en_out, ((mon_since < 0) && en_in) ? 1'b1 : 1'b0);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (en_rand) en_in = 1'($urandom_range(1, 0));
      end
   end

   initial begin
      bus.cfg_word  = '0;
      bus.cfg_valid = 1'b0;
      bus.cfg_abort = 1'b0;
`ifdef MAC_CFG_PARITY_EN
      bus.cfg_parity = 1'b0;
`endif
      // reset state
      #2;
      check("rst_cset", cset, '0);
      check("rst_done", done, '0);
      check("rst_busy", busy, '0);
      check("rst_cfg", cfg, '0);
      check("rst_ready", bus.cfg_ready, '0);
      check("rst_en_out", en_out, '0);
      #10 rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", bus.cfg_ready, 1'b1);
      check("post_rst_busy", busy, '0);
      @(posedge clk);
      #1;

      // directed load
      use_literal = 1'b1;
      literal_cfg = 132'h4_3333_3333_2222_2222_1111_1111_0000_0007;
      send_word(32'h0000_0007, 1'b0);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b0);
      send_word(32'h3333_3333, 1'b0);
      send_word(32'h0000_0004, 1'b0);
      bus.cfg_valid = 1'b0;
      use_literal = 1'b0;
      @(negedge clk);
      check("dir_cset", cset, 1'b1);
      check("dir_mode", cfg[mode_lsb() +: CW], 4'h7);
      check("dir_init0", cfg[init_lsb(0, AW, CW) +: AW], 32'h1000_0000);
      check("dir_init3", cfg[init_lsb(3, AW, CW) +: AW], 32'h4333_3333);
      @(negedge clk);
      check("dir_cset_off", cset, '0);
      check("dir_busy", busy, 1'b1);
      idle(4);

      // valid held high through commit: sixth word waits for IDLE
      en_rand = 1'b1;
      for (int i = 0; i < NW + 1; i++) send_word($urandom, 1'b0);
      for (int i = 0; i < NW - 1; i++) send_word($urandom, 1'b0);
      idle(5);

      // abort after 3 words, abort and valid together
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
      bus.cfg_word  = $urandom;
      bus.cfg_valid = 1'b1;
      bus.cfg_abort = 1'b1;
      @(posedge clk);
      #1;
      bus.cfg_abort = 1'b0;
      bus.cfg_valid = 1'b0;
      cur.delete();
      @(negedge clk);
      check("abort_busy", busy, '0);
      idle(2);
      rand_load();
      idle(5);

      // async reset in the middle of FLUSH
      rand_load();
      bus.cfg_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_cset", cset, '0);
      check("arst_done", done, '0);
      check("arst_busy", busy, '0);
      check("arst_cfg", cfg, '0);
      check("arst_ready", bus.cfg_ready, '0);
      check("arst_en_out", en_out, '0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      check("arst_rel_ready", bus.cfg_ready, 1'b1);
      idle(4);

`ifdef MAC_CFG_PARITY_EN
      send_word($urandom, 1'b0);
      send_word($urandom, 1'b1);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      check("par_err_set", bus.cfg_err, 1'b1);
      check("par_busy", busy, '0);
      idle(3);
      check("par_err_sticky", bus.cfg_err, 1'b1);
      send_word($urandom, 1'b0);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      check("par_err_clr", bus.cfg_err, '0);
      for (int i = 0; i < NW - 1; i++) send_word($urandom, 1'b0);
      idle(5);
`endif

      // randomized loads with occasional aborts
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(3, 0) == 0) begin
            for (int i = 0; i < $urandom_range(NW - 1, 1); i++) send_word($urandom, 1'b0);
            bus.cfg_valid = $urandom_range(1, 0) == 1;
            bus.cfg_word  = $urandom;
            bus.cfg_abort = 1'b1;
            @(posedge clk);
            #1;
            bus.cfg_abort = 1'b0;
            cur.delete();
            idle(1);
         end
         rand_load();
         if ($urandom_range(1, 0) == 0) idle($urandom_range(4, 1));
      end
      idle(10);
      check("queue_drained", exp_q.size(), '0);
      check("partial_clear", cur.size(), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
